// File: rtl/div_16_5_stream_check.sv
// Two-stage valid/ready wrapper around an external divide-by-5 block.
// Each quotient/remainder is checked against its dividend, and pass/fail statistics are kept.
module div_16_5_stream_check #(
    parameter int DATA_W  = 16,
    parameter int Q_W     = 14,
    parameter int R_W     = 3,
    parameter int DIVISOR = 5,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    output logic [DATA_W-1:0] div_x,
    input  logic [Q_W-1:0]    div_q,
    input  logic [R_W-1:0]    div_r,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_x,
    output logic [Q_W-1:0]    out_q,
    output logic [R_W-1:0]    out_r,
    output logic              out_ok,
    input  logic              clear,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_flag,
    output logic [DATA_W-1:0] first_err_x
);

    // One spare bit lets an oversized quotient (q*5 > 65535) register as a mismatch, not alias.
    localparam int EXT_W = DATA_W + 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic div_ok(input logic [DATA_W-1:0] x,
                                    input logic [Q_W-1:0]    q,
                                    input logic [R_W-1:0]    r);
        logic [EXT_W-1:0] sum;
        sum = EXT_W'(q) * EXT_W'(DIVISOR) + EXT_W'(r);
        return (sum == EXT_W'(x)) && (EXT_W'(r) < EXT_W'(DIVISOR));
    endfunction

    logic              r_s1_v;
    logic [DATA_W-1:0] r_s1_x;
    logic              r_s2_v;
    logic [DATA_W-1:0] r_s2_x;
    logic [Q_W-1:0]    r_s2_q;
    logic [R_W-1:0]    r_s2_r;
    logic              r_s2_ok;
    logic [CNT_W-1:0]  r_pass;
    logic [CNT_W-1:0]  r_err;
    logic              r_err_flag;
    logic [DATA_W-1:0] r_first_x;

    logic              w_s2_drain;
    logic              w_s1_adv;
    logic              w_accept;
    logic              w_ok;
    logic [CNT_W-1:0]  w_pass_base, w_pass_nxt;
    logic [CNT_W-1:0]  w_err_base, w_err_nxt;
    logic              w_flag_base, w_flag_nxt;
    logic [DATA_W-1:0] w_first_base, w_first_nxt;

    assign w_s2_drain = r_s2_v & out_ready;
    assign w_s1_adv   = r_s1_v & (~r_s2_v | w_s2_drain);
    assign in_ready   = ~r_s1_v | w_s1_adv;
    assign w_accept   = in_valid & in_ready;
    assign w_ok       = div_ok(r_s1_x, div_q, div_r);

    // Stage 1: dividend register, which also drives the divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v <= 1'b0;
            r_s1_x <= '0;
        end else if (w_accept) begin
            r_s1_v <= 1'b1;
            r_s1_x <= in_x;
        end else if (w_s1_adv) begin
            r_s1_v <= 1'b0;
        end
    end

    // Stage 2: captured result and check outcome, held until drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v  <= 1'b0;
            r_s2_x  <= '0;
            r_s2_q  <= '0;
            r_s2_r  <= '0;
            r_s2_ok <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_v  <= 1'b1;
            r_s2_x  <= r_s1_x;
            r_s2_q  <= div_q;
            r_s2_r  <= div_r;
            r_s2_ok <= w_ok;
        end else if (w_s2_drain) begin
            r_s2_v  <= 1'b0;
        end
    end

    // Clear is applied first, so an event captured in the same cycle lands on zeroed statistics.
    always_comb begin
        w_pass_base  = clear ? '0 : r_pass;
        w_err_base   = clear ? '0 : r_err;
        w_flag_base  = clear ? 1'b0 : r_err_flag;
        w_first_base = clear ? '0 : r_first_x;
        w_pass_nxt   = w_pass_base;
        w_err_nxt    = w_err_base;
        w_flag_nxt   = w_flag_base;
        w_first_nxt  = w_first_base;
        if (w_s1_adv) begin
            if (w_ok) begin
                w_pass_nxt = sat_inc(w_pass_base);
            end else begin
                w_err_nxt  = sat_inc(w_err_base);
                w_flag_nxt = 1'b1;
                if (!w_flag_base) begin
                    w_first_nxt = r_s1_x;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass     <= '0;
            r_err      <= '0;
            r_err_flag <= 1'b0;
            r_first_x  <= '0;
        end else begin
            r_pass     <= w_pass_nxt;
            r_err      <= w_err_nxt;
            r_err_flag <= w_flag_nxt;
            r_first_x  <= w_first_nxt;
        end
    end

    assign div_x       = r_s1_x;
    assign out_valid   = r_s2_v;
    assign out_x       = r_s2_x;
    assign out_q       = r_s2_q;
    assign out_r       = r_s2_r;
    assign out_ok      = r_s2_ok;
    assign pass_count  = r_pass;
    assign err_count   = r_err;
    assign err_flag    = r_err_flag;
    assign first_err_x = r_first_x;

endmodule

// File: tb/tb_div_16_5_stream_check.sv
// Directed bench for div_16_5_stream_check with a behavioural divider (optionally faulty)
// and a second instance at CNT_W=4 for counter saturation.
module tb_div_16_5_stream_check;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_x;
    logic        out_ready;
    logic        clear;
    logic        fault_en;

    logic        in_ready, out_valid, out_ok, err_flag;
    logic [15:0] div_x, out_x, first_err_x;
    logic [13:0] div_q, out_q;
    logic [2:0]  div_r, out_r;
    logic [15:0] pass_count, err_count;

    logic        sm_in_ready, sm_out_valid, sm_out_ok, sm_err_flag;
    logic [15:0] sm_div_x, sm_out_x, sm_first_err_x;
    logic [13:0] sm_div_q, sm_out_q;
    logic [2:0]  sm_div_r, sm_out_r;
    logic [3:0]  sm_pass_count, sm_err_count;

    int n_vec;
    int n_miss;

    div_16_5_stream_check dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .div_x(div_x), .div_q(div_q), .div_r(div_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_q(out_q),
        .out_r(out_r), .out_ok(out_ok), .clear(clear), .pass_count(pass_count),
        .err_count(err_count), .err_flag(err_flag), .first_err_x(first_err_x)
    );

    div_16_5_stream_check #(.CNT_W(4)) dut_sm (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sm_in_ready), .in_x(in_x),
        .div_x(sm_div_x), .div_q(sm_div_q), .div_r(sm_div_r),
        .out_valid(sm_out_valid), .out_ready(out_ready), .out_x(sm_out_x), .out_q(sm_out_q),
        .out_r(sm_out_r), .out_ok(sm_out_ok), .clear(clear), .pass_count(sm_pass_count),
        .err_count(sm_err_count), .err_flag(sm_err_flag), .first_err_x(sm_first_err_x)
    );

    // Divider model: x=5 gives q=0,r=5 and x=6 gives q=0 when faults are enabled.
    always_comb begin
        div_q = 14'(div_x / 16'd5);
        div_r = 3'(div_x % 16'd5);
        if (fault_en && div_x == 16'd5) begin
            div_q = 14'd0;
            div_r = 3'd5;
        end
        if (fault_en && div_x == 16'd6) begin
            div_q = 14'd0;
        end
    end

    always_comb begin
        sm_div_q = 14'(sm_div_x / 16'd5);
        sm_div_r = 3'(sm_div_x % 16'd5);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    typedef struct {
        logic [15:0] x;
        logic [13:0] q;
        logic [2:0]  r;
        logic        ok;
    } vec_t;

    vec_t        tbl[6];
    logic [15:0] rx[1000];

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        out_ready = 1'b1;
        clear     = 1'b0;
        fault_en  = 1'b0;

        tbl[0] = '{16'd65535, 14'd13107, 3'd0, 1'b1};
        tbl[1] = '{16'd7,     14'd1,     3'd2, 1'b1};
        tbl[2] = '{16'd0,     14'd0,     3'd0, 1'b1};
        tbl[3] = '{16'd12345, 14'd2469,  3'd0, 1'b1};
        tbl[4] = '{16'd9,     14'd1,     3'd4, 1'b1};
        tbl[5] = '{16'd65534, 14'd13106, 3'd4, 1'b1};

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ok", out_ok, 0);
        chk("rst_pass", pass_count, 0);
        chk("rst_err", err_count, 0);
        chk("rst_div_x", div_x, 0);
        rst_n = 1'b1;

        // single transactions, two-edge latency
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_x     = tbl[i].x;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            chk("tbl_valid", out_valid, 1);
            chk("tbl_x", out_x, tbl[i].x);
            chk("tbl_q", out_q, tbl[i].q);
            chk("tbl_r", out_r, tbl[i].r);
            chk("tbl_ok", out_ok, tbl[i].ok);
            if (i == 0) chk("tbl_pass_first", pass_count, 1);
        end
        chk("tbl_pass_total", pass_count, 6);

        // backpressure: three offered, two fit, then drain in order
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_x      = 16'd10;
        @(negedge clk);
        chk("bp_ready_after1", in_ready, 1);
        in_x = 16'd11;
        @(negedge clk);
        in_x = 16'd12;
        chk("bp_ready_full", in_ready, 0);
        @(negedge clk);
        chk("bp_hold_ready", in_ready, 0);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_x", out_x, 10);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_release", in_ready, 1);
        chk("bp_r0_x", out_x, 10);
        chk("bp_r0_qr", {out_q, out_r}, {14'd2, 3'd0});
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_r1_x", out_x, 11);
        chk("bp_r1_qr", {out_q, out_r}, {14'd2, 3'd1});
        @(negedge clk);
        chk("bp_r2_x", out_x, 12);
        chk("bp_r2_qr", {out_q, out_r}, {14'd2, 3'd2});
        @(negedge clk);
        chk("bp_empty", out_valid, 0);

        // faulty divider results
        pulse_clear();
        fault_en = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = 16'd5;
        @(negedge clk);
        in_x = 16'd6;
        @(negedge clk);
        in_valid = 1'b0;
        chk("flt5_x", out_x, 5);
        chk("flt5_ok", out_ok, 0);
        chk("flt5_r", out_r, 5);
        @(negedge clk);
        chk("flt6_x", out_x, 6);
        chk("flt6_ok", out_ok, 0);
        chk("flt6_q", out_q, 0);
        chk("flt_err_count", err_count, 2);
        chk("flt_err_flag", err_flag, 1);
        chk("flt_first_x", first_err_x, 5);
        chk("flt_pass", pass_count, 0);
        pulse_clear();
        chk("clr_err", err_count, 0);
        chk("clr_flag", err_flag, 0);
        chk("clr_first", first_err_x, 0);
        chk("clr_pass", pass_count, 0);

        // capture in the same cycle as clear
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = 16'd5;
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("cc_err", err_count, 1);
        chk("cc_flag", err_flag, 1);
        chk("cc_first", first_err_x, 5);
        fault_en = 1'b0;
        pulse_clear();

        // 20 passes: full-width counts 20, 4-bit counter sticks at 15
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_x     = 16'(i * 333 + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("sat_pass16", pass_count, 20);
        chk("sat_pass4", sm_pass_count, 15);
        chk("sat_err4", sm_err_count, 0);

        // 1000 back-to-back random dividends
        pulse_clear();
        for (int i = 0; i < 1000; i++) rx[i] = 16'($urandom);
        for (int i = 0; i < 1002; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk("rnd_valid", out_valid, 1);
                chk("rnd_x", out_x, rx[i-2]);
                chk("rnd_qr", {out_q, out_r}, {14'(rx[i-2] / 16'd5), 3'(rx[i-2] % 16'd5)});
            end
            if (i < 1000) begin
                in_valid = 1'b1;
                in_x     = rx[i];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("rnd_drained", out_valid, 0);
        chk("rnd_pass", pass_count, 1000);
        chk("rnd_err", err_count, 0);

        // asynchronous reset with the pipeline full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_x      = 16'd100;
        @(negedge clk);
        in_x = 16'd200;
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_valid", out_valid, 1);
        chk("full_ready", in_ready, 0);
        chk("full_pass_nz", pass_count, 1001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_pass", pass_count, 0);
        chk("arst_err", err_count, 0);
        chk("arst_div_x", div_x, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_no_restore", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
